// File: rtl/half_fixed_layer_sequencer_if.sv
// Bundle between the layer sequencer, the scheduler, the matrix-dot-vector engine
// and its weight / input / output memories.
interface half_fixed_layer_sequencer_if #(
    parameter int BITS   = 16,
    parameter int WIDTH  = 40,
    parameter int HEIGHT = 10,
    parameter int MULTS  = 2
);
    localparam int NW   = HEIGHT * WIDTH / MULTS;
    localparam int NX   = WIDTH / MULTS;
    localparam int WA_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int XA_W = (NX > 1) ? $clog2(NX) : 1;
    localparam int YA_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic                    start;
    logic                    reload_weights;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic                    w_rd_en;
    logic [WA_W-1:0]         w_addr;
    logic [MULTS*BITS-1:0]   w_data;
    logic                    x_rd_en;
    logic [XA_W-1:0]         x_addr;
    logic [MULTS*BITS-1:0]   x_data;
    logic                    load_matrix;
    logic [MULTS*BITS-1:0]   matrix_a_in;
    logic                    in_valid;
    logic [MULTS*BITS-1:0]   vector_b;
    logic                    out_valid;
    logic [BITS-1:0]         c;
    logic                    y_we;
    logic [YA_W-1:0]         y_addr;
    logic [BITS-1:0]         y_data;

    modport master (
        input  start, reload_weights, w_data, x_data, out_valid, c,
        output busy, done, error, w_rd_en, w_addr, x_rd_en, x_addr,
               load_matrix, matrix_a_in, in_valid, vector_b, y_we, y_addr, y_data
    );

    modport slave (
        output start, reload_weights, w_data, x_data, out_valid, c,
        input  busy, done, error, w_rd_en, w_addr, x_rd_en, x_addr,
               load_matrix, matrix_a_in, in_valid, vector_b, y_we, y_addr, y_data
    );
endinterface

// File: rtl/half_fixed_layer_sequencer.sv
// Sequences one fully-connected layer: optional weight load, vector load, then
// collects HEIGHT serial engine results into the output buffer with a timeout.
module half_fixed_layer_sequencer #(
    parameter int BITS    = 16,
    parameter int WIDTH   = 40,
    parameter int HEIGHT  = 10,
    parameter int MULTS   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    half_fixed_layer_sequencer_if.master  bus
);
    localparam int NW   = HEIGHT * WIDTH / MULTS;
    localparam int NX   = WIDTH / MULTS;
    localparam int WA_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int XA_W = (NX > 1) ? $clog2(NX) : 1;
    localparam int YA_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int RC_W = $clog2(HEIGHT + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, WAIT_Y, FINISH} state_t;

    state_t          state;
    logic [RC_W-1:0] res_cnt;
    logic [TC_W-1:0] tmo_cnt;
    logic            err_flag;

    // Memory read data arrives in the cycle the delayed strobe is high, so it
    // is forwarded straight to the engine.
    assign bus.matrix_a_in = bus.w_data;
    assign bus.vector_b    = bus.x_data;

    // NOTE: every register below is updated with <= so all reads in this block
    // see the previous-cycle values, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            res_cnt         <= '0;
            tmo_cnt         <= '0;
            err_flag        <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.w_rd_en     <= 1'b0;
            bus.w_addr      <= '0;
            bus.x_rd_en     <= 1'b0;
            bus.x_addr      <= '0;
            bus.load_matrix <= 1'b0;
            bus.in_valid    <= 1'b0;
            bus.y_we        <= 1'b0;
            bus.y_addr      <= '0;
            bus.y_data      <= '0;
        end else begin
            bus.load_matrix <= bus.w_rd_en;
            bus.in_valid    <= bus.x_rd_en;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            bus.y_we        <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        if (bus.reload_weights) begin
                            state       <= LOAD_W;
                            bus.w_rd_en <= 1'b1;
                            bus.w_addr  <= '0;
                        end else begin
                            state       <= LOAD_X;
                            bus.x_rd_en <= 1'b1;
                            bus.x_addr  <= '0;
                        end
                    end
                end

                LOAD_W: begin
                    if (bus.w_addr == WA_W'(NW - 1)) begin
                        state       <= LOAD_X;
                        bus.w_rd_en <= 1'b0;
                        bus.w_addr  <= '0;
                        bus.x_rd_en <= 1'b1;
                        bus.x_addr  <= '0;
                    end else begin
                        bus.w_addr <= bus.w_addr + 1'b1;
                    end
                end

                LOAD_X: begin
                    if (bus.x_addr == XA_W'(NX - 1)) begin
                        state       <= WAIT_Y;
                        bus.x_rd_en <= 1'b0;
                        bus.x_addr  <= '0;
                        res_cnt     <= '0;
                        tmo_cnt     <= '0;
                        err_flag    <= 1'b0;
                    end else begin
                        bus.x_addr <= bus.x_addr + 1'b1;
                    end
                end

                WAIT_Y: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    // A capture on the final timeout cycle still counts.
                    if (bus.out_valid) begin
                        bus.y_we   <= 1'b1;
                        bus.y_addr <= YA_W'(res_cnt);
                        bus.y_data <= bus.c;
                        res_cnt    <= res_cnt + 1'b1;
                    end
                    if (bus.out_valid && res_cnt == RC_W'(HEIGHT - 1)) begin
                        state    <= FINISH;
                        err_flag <= 1'b0;
                    end else if (tmo_cnt == TC_W'(TIMEOUT - 1)) begin
                        state    <= FINISH;
                        err_flag <= 1'b1;
                    end
                end

                FINISH: begin
                    state     <= IDLE;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b1;
                    bus.error <= err_flag;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
